// File: rtl/ramen_countdown.sv
`default_nettype none
// ============================================================================
// Module  : ramen_countdown
// Brief   : Ramen timer front end: key debounce, minute preset selection and
//           BCD mm:ss countdown driven by an external 1 s tick.
// Rev     : 1.0  initial release
// ============================================================================
module ramen_countdown #(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int DEFAULT_MIN     = 3,
    parameter int MAX_MIN         = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic [1:0] key_n,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       timeup,
    output logic       blink
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]         c_max_tens = 4'(MAX_MIN / 10);
    localparam logic [3:0]         c_max_ones = 4'(MAX_MIN % 10);
    localparam logic [3:0]         c_def_tens = 4'(DEFAULT_MIN / 10);
    localparam logic [3:0]         c_def_ones = 4'(DEFAULT_MIN % 10);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0] w_press;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic               r_sync1;
            logic               r_sync2;
            logic               r_level;
            logic               r_event;
            logic [c_cnt_w-1:0] r_cnt;

            // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_level <= 1'b1;
                    r_event <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= key_n[gi];
                    r_sync2 <= r_sync1;
                    r_event <= 1'b0;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_level <= r_sync2;
                        r_event <= ~r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_event;
        end
    endgenerate

    logic [1:0] r_state;
    logic [3:0] r_pre_tens;
    logic [3:0] r_pre_ones;
    logic [3:0] r_mt;
    logic [3:0] r_mo;
    logic [3:0] r_st;
    logic [3:0] r_so;
    logic       r_blink;

    logic [3:0] w_dec_mt;
    logic [3:0] w_dec_mo;
    logic [3:0] w_dec_st;
    logic [3:0] w_dec_so;
    logic       w_dec_zero;
    logic [3:0] w_inc_tens;
    logic [3:0] w_inc_ones;

    // BCD borrow chain; never evaluated on 00:00 since RUN leaves on reaching it.
    always_comb begin
        w_dec_mt = r_mt;
        w_dec_mo = r_mo;
        w_dec_st = r_st;
        w_dec_so = r_so - 4'd1;
        if (r_so == 4'd0) begin
            w_dec_so = 4'd9;
            w_dec_st = r_st - 4'd1;
            if (r_st == 4'd0) begin
                w_dec_st = 4'd5;
                w_dec_mo = r_mo - 4'd1;
                if (r_mo == 4'd0) begin
                    w_dec_mo = 4'd9;
                    w_dec_mt = r_mt - 4'd1;
                end
            end
        end
    end

    assign w_dec_zero = (w_dec_mt == 4'd0) && (w_dec_mo == 4'd0) &&
                        (w_dec_st == 4'd0) && (w_dec_so == 4'd0);

    always_comb begin
        w_inc_tens = r_pre_tens;
        w_inc_ones = r_pre_ones + 4'd1;
        if ((r_pre_tens == c_max_tens) && (r_pre_ones == c_max_ones)) begin
            w_inc_tens = 4'd0;
            w_inc_ones = 4'd1;
        end else if (r_pre_ones == 4'd9) begin
            w_inc_tens = r_pre_tens + 4'd1;
            w_inc_ones = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_pre_tens <= c_def_tens;
            r_pre_ones <= c_def_ones;
            r_mt       <= c_def_tens;
            r_mo       <= c_def_ones;
            r_st       <= 4'd0;
            r_so       <= 4'd0;
            r_blink    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_press[0]) begin
                        r_state <= c_st_run;
                        r_mt    <= r_pre_tens;
                        r_mo    <= r_pre_ones;
                        r_st    <= 4'd0;
                        r_so    <= 4'd0;
                    end else if (w_press[1]) begin
                        r_pre_tens <= w_inc_tens;
                        r_pre_ones <= w_inc_ones;
                        r_mt       <= w_inc_tens;
                        r_mo       <= w_inc_ones;
                    end
                end
                c_st_run: begin
                    if (tick_1s) begin
                        r_mt <= w_dec_mt;
                        r_mo <= w_dec_mo;
                        r_st <= w_dec_st;
                        r_so <= w_dec_so;
                        if (w_dec_zero) begin
                            r_state <= c_st_done;
                        end else if (w_press[0]) begin
                            r_state <= c_st_pause;
                        end
                    end else if (w_press[0]) begin
                        r_state <= c_st_pause;
                    end
                end
                c_st_pause: begin
                    if (w_press[1]) begin
                        r_state <= c_st_idle;
                        r_mt    <= r_pre_tens;
                        r_mo    <= r_pre_ones;
                        r_st    <= 4'd0;
                        r_so    <= 4'd0;
                    end else if (w_press[0]) begin
                        r_state <= c_st_run;
                    end
                end
                c_st_done: begin
                    if (w_press[0] || w_press[1]) begin
                        r_state <= c_st_idle;
                        r_mt    <= r_pre_tens;
                        r_mo    <= r_pre_ones;
                        r_st    <= 4'd0;
                        r_so    <= 4'd0;
                        r_blink <= 1'b0;
                    end else if (tick_1s) begin
                        r_blink <= ~r_blink;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign min_tens = r_mt;
    assign min_ones = r_mo;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
    assign running  = (r_state == c_st_run);
    assign timeup   = (r_state == c_st_done);
    assign blink    = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_ramen_countdown.sv
`default_nettype none
// ============================================================================
// Module  : tb_ramen_countdown
// Brief   : Self-checking bench for ramen_countdown against a seconds-count
//           model of the timer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ramen_countdown;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1s = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, timeup, blink;

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 idle, 1 run, 2 pause, 3 done; m_val is remaining seconds.
    int m_mode, m_preset, m_val;
    bit m_blink;

    ramen_countdown #(
        .DEBOUNCE_CYCLES(D),
        .DEFAULT_MIN    (3),
        .MAX_MIN        (59)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_1s (tick_1s),
        .key_n   (key_n),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .running (running),
        .timeup  (timeup),
        .blink   (blink)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_preset = 3; m_val = 180; m_blink = 0;
    endtask

    task automatic model_tick();
        if (m_mode == 1) begin
            m_val--;
            if (m_val == 0) m_mode = 3;
        end else if (m_mode == 3) begin
            m_blink = ~m_blink;
        end
    endtask

    task automatic model_press(int k);
        case (m_mode)
            0: if (k == 0) begin m_mode = 1; m_val = m_preset * 60; end
               else begin m_preset = (m_preset == 59) ? 1 : m_preset + 1; m_val = m_preset * 60; end
            1: if (k == 0) m_mode = 2;
            2: if (k == 1) begin m_mode = 0; m_val = m_preset * 60; end
               else m_mode = 1;
            default: begin m_mode = 0; m_val = m_preset * 60; m_blink = 0; end
        endcase
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag, bit wait_edge);
        int v;
        if (wait_edge) @(negedge clk);
        v = (m_mode == 0) ? m_preset * 60 : m_val;
        chk({tag, ".min_tens"}, min_tens, 4'((v / 60) / 10));
        chk({tag, ".min_ones"}, min_ones, 4'((v / 60) % 10));
        chk({tag, ".sec_tens"}, sec_tens, 4'((v % 60) / 10));
        chk({tag, ".sec_ones"}, sec_ones, 4'((v % 60) % 10));
        chk({tag, ".running"}, {3'b0, running}, {3'b0, m_mode == 1});
        chk({tag, ".timeup"},  {3'b0, timeup},  {3'b0, m_mode == 3});
        chk({tag, ".blink"},   {3'b0, blink},   {3'b0, m_blink});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic press(int k);
        key_n[k] = 1'b0;
        step(D + 4);
        key_n[k] = 1'b1;
        step(D + 4);
        model_press(k);
    endtask

    task automatic tick();
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
        model_tick();
    endtask

    task automatic glitch(int k, int len);
        key_n[k] = 1'b0;
        step(len);
        key_n[k] = 1'b1;
        step(D + 6);
    endtask

    initial begin
        model_reset();
        // Reset state and idle hold
        do_reset();
        check_all("reset", 1);
        step(100);
        check_all("idle_hold", 1);

        // Short glitch is rejected; a real press increments, then wrap 59->1
        glitch(1, 2);
        check_all("glitch", 1);
        press(1);
        check_all("preset4", 1);
        for (int i = 0; i < 56; i++) begin
            press(1);
            check_all("preset_walk", 1);
        end

        // One-minute countdown to DONE, then blink
        press(0);
        check_all("start_1min", 1);
        for (int i = 0; i < 60; i++) begin
            tick();
            check_all("count_1min", 1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("done_blink", 1);
        end

        // Preset 10, full borrow, pause holds
        press(1);
        check_all("back_idle", 1);
        for (int i = 0; i < 9; i++) press(1);
        check_all("preset10", 1);
        press(0);
        tick();
        check_all("borrow_0959", 1);
        press(0);
        check_all("paused", 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("pause_hold", 1);
        end
        press(0);
        check_all("resumed", 1);
        tick();
        check_all("resume_0958", 1);

        // Down to 00:01, then tick and start/pause land together
        for (int i = 0; i < 597; i++) begin
            tick();
            check_all("count_down", 1);
        end
        key_n[0] = 1'b0;
        step(D + 2);
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
        model_tick();
        if (m_mode == 1) m_mode = 2;
        step(D + 2);
        key_n[0] = 1'b1;
        step(D + 4);
        check_all("tick_press_done", 1);
        press(1);
        check_all("done_clear", 1);

        // Asynchronous reset mid-run at 02:17
        do_reset();
        press(0);
        for (int i = 0; i < 43; i++) tick();
        check_all("at_0217", 1);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst", 0);
        step(1);
        rst = 1'b0;
        step(1);
        check_all("after_rst", 1);

        // Randomised operation mix
        for (int i = 0; i < 150; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                press(0);
            end else if (op == 2) begin
                press(1);
            end else if (op == 3) begin
                glitch($urandom_range(0, 1), $urandom_range(1, D - 1));
            end else begin
                int n;
                n = $urandom_range(1, 30);
                for (int j = 0; j < n; j++) begin
                    tick();
                    step($urandom_range(0, 2));
                end
            end
            check_all("random", 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
